// File: rtl/boot_loader.sv
// boot_loader: receives a boot image as a UART byte stream and writes it into
// the data memory banks one 32-bit word at a time.
//
// Frame: 0xA5, count[7:0], count[15:8], count*4 data bytes (LSB first), XOR checksum.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   debug      one-cycle word-write strobe to the memory banks
//   boot_addr  word index being written (zero-extended)
//   boot_data  word being written (bits [7:0] -> bank 0 ... [31:24] -> bank 3)
//   cpu_halt   holds the CPU while an image is incomplete or invalid
//   boot_done  last load completed with a good checksum
//   boot_err   last load failed
module boot_loader #(
    parameter int unsigned MAX_WORDS      = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        debug,
    output logic [31:0] boot_addr,
    output logic [31:0] boot_data,
    output logic        cpu_halt,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CNT_LO = 3'd1;
    localparam logic [2:0] CNT_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]    state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   word_q,  word_d;
    logic [1:0]    byte_q,  byte_d;
    logic [7:0]    csum_q,  csum_d;
    logic [31:0]   data_q,  data_d;
    logic [15:0]   addr_q,  addr_d;
    logic          debug_q, debug_d;
    logic [TW-1:0] tmo_q,   tmo_d;

    logic active;
    logic timed_out;
    logic last_word_out;

    assign active    = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);
    assign timed_out = active && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // The final word's strobe is on the wire; the frame's data phase is over.
    assign last_word_out = debug_q && (word_q == count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        byte_d  = byte_q;
        csum_d  = csum_q;
        data_d  = data_q;
        addr_d  = addr_q;
        debug_d = 1'b0;

        if (rx_valid || !active) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (rx_valid && rx_data == 8'hA5) begin
                    state_d = CNT_LO;
                    word_d  = '0;
                    byte_d  = '0;
                    csum_d  = '0;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    count_d[7:0] = rx_data;
                    state_d      = CNT_HI;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    count_d[15:8] = rx_data;
                    if ({rx_data, count_q[7:0]} == 16'd0) begin
                        state_d = CHECK;
                    end else if ({1'b0, rx_data, count_q[7:0]} > 17'(MAX_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word_out) begin
                    // A byte arriving alongside the last strobe is the checksum.
                    if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? DONE : ERROR;
                    end else begin
                        state_d = CHECK;
                    end
                end else if (rx_valid) begin
                    case (byte_q)
                        2'd0:    data_d[7:0]   = rx_data;
                        2'd1:    data_d[15:8]  = rx_data;
                        2'd2:    data_d[23:16] = rx_data;
                        default: data_d[31:24] = rx_data;
                    endcase
                    csum_d = csum_q ^ rx_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        debug_d = 1'b1;
                        addr_d  = word_q;
                        word_d  = word_q + 16'd1;
                    end
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timed_out) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            debug_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            debug_q <= debug_d;
            tmo_q   <= tmo_d;
        end
    end

    assign debug     = debug_q;
    assign boot_addr = {16'b0, addr_q};
    assign boot_data = data_q;
    assign cpu_halt  = active || (state_q == ERROR);
    assign boot_done = (state_q == DONE);
    assign boot_err  = (state_q == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: directed frames plus randomized frames; expected
// write strobes are derived from each frame's byte positions.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        debug;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        cpu_halt;
    logic        boot_done;
    logic        boot_err;

    boot_loader #(
        .MAX_WORDS      (8192),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .debug     (debug),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .cpu_halt  (cpu_halt),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expectation for the write strobe in the cycle being sampled.
    logic        exp_dbg  = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    logic [31:0] words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample on the falling edge and check the strobe.
    task automatic tick();
        @(negedge clk);
        chk("debug", 32'(debug), 32'(exp_dbg));
        if (exp_dbg) begin
            chk("boot_addr", boot_addr, exp_addr);
            chk("boot_data", boot_data, exp_data);
        end
    endtask

    task automatic status(input string tag, input bit halt, input bit done, input bit err);
        chk({tag, ".halt"}, 32'(cpu_halt), 32'(halt));
        chk({tag, ".done"}, 32'(boot_done), 32'(done));
        chk({tag, ".err"},  32'(boot_err), 32'(err));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        exp_dbg  = wr;
        exp_addr = a;
        exp_data = d;
        tick();
        exp_dbg  = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends a complete frame carrying words[0..n-1]; every 4th data byte must
    // produce a write of that word at its index in the following cycle.
    task automatic send_frame(input string tag, input int n, input bit corrupt, input int gmax);
        logic [15:0] n16;
        logic [7:0]  cs;
        logic [7:0]  b;
        n16 = 16'(n);
        cs  = 8'h00;
        send_byte(8'hA5, 1'b0, '0, '0, $urandom_range(gmax, 0));
        status({tag, ".start"}, 1'b1, 1'b0, 1'b0);
        send_byte(n16[7:0], 1'b0, '0, '0, $urandom_range(gmax, 0));
        send_byte(n16[15:8], 1'b0, '0, '0, $urandom_range(gmax, 0));
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b  = words[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, k == 3, 32'(w), words[w], $urandom_range(gmax, 0));
            end
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs, 1'b0, '0, '0, 0);
        tick();
        status({tag, ".end"}, corrupt, !corrupt, corrupt);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();
        chk("rst.addr", boot_addr, 32'h0);
        chk("rst.data", boot_data, 32'h0);
        status("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Two-word frame with good checksum (0x44).
        words = '{32'h44332211, 32'hDDCCBBAA};
        send_frame("good2", 2, 1'b0, 0);

        // Same frame with a wrong checksum, then a new magic clears the error.
        send_frame("bad2", 2, 1'b1, 1);
        send_byte(8'hA5, 1'b0, '0, '0, 0);
        status("restart", 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        status("restart.tmo", 1'b1, 1'b0, 1'b1);

        // Empty image.
        words = '{};
        send_frame("empty", 0, 1'b0, 0);

        // Count 8193 exceeds capacity.
        send_byte(8'hA5, 1'b0, '0, '0, 0);
        send_byte(8'h01, 1'b0, '0, '0, 0);
        send_byte(8'h20, 1'b0, '0, '0, 0);
        status("toolong", 1'b1, 1'b0, 1'b1);
        repeat (3) tick();

        // Silence after the first data byte.
        send_byte(8'hA5, 1'b0, '0, '0, 0);
        send_byte(8'h01, 1'b0, '0, '0, 0);
        send_byte(8'h00, 1'b0, '0, '0, 0);
        send_byte(8'h11, 1'b0, '0, '0, 0);
        repeat (10) tick();
        status("tmo.early", 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        status("tmo.late", 1'b1, 1'b0, 1'b1);

        // Reset mid-frame after the 2nd data byte.
        send_byte(8'hA5, 1'b0, '0, '0, 0);
        send_byte(8'h02, 1'b0, '0, '0, 0);
        send_byte(8'h00, 1'b0, '0, '0, 0);
        send_byte(8'h11, 1'b0, '0, '0, 0);
        send_byte(8'h22, 1'b0, '0, '0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.addr", boot_addr, 32'h0);
        chk("midrst.data", boot_data, 32'h0);
        status("midrst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'h11, 1'b0, '0, '0, 0);
        status("stray", 1'b0, 1'b0, 1'b0);

        // Randomized frames, back-to-back and gapped.
        for (int f = 0; f < 8; f++) begin
            int n;
            n = int'($urandom_range(6, 1));
            words = '{};
            for (int w = 0; w < n; w++) words.push_back($urandom);
            send_frame("rand", n, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
            repeat (2) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
